// File: rtl/wb_pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : wb_pwm_pkg
//  Purpose : Shared constants and types for the buffered Wishbone PWM block:
//            register word addresses, CTRL bit positions, counter direction.
//  Rev     : 1.0  initial release
// ============================================================================
package wb_pwm_pkg;

    // Word addresses of the configuration registers (DUTY[n] sits at n)
    localparam logic [3:0] ADR_INVERT   = 4'hD;
    localparam logic [3:0] ADR_PRESCALE = 4'hE;
    localparam logic [3:0] ADR_CTRL     = 4'hF;

    // CTRL register bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_CENTER = 1;

    // Shared counter direction (only meaningful in center-aligned mode)
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

endpackage : wb_pwm_pkg
`default_nettype wire

// File: rtl/wb_pwm_buffered_channel.sv
`default_nettype none
// ============================================================================
//  Module  : wb_pwm_buffered_channel
//  Purpose : One PWM output. Holds the bus-visible shadow duty and the active
//            duty used by the comparator; active reloads at period boundaries
//            (or continuously while disabled). Output is registered and
//            polarity-adjusted.
//  Rev     : 1.0  initial release
// ============================================================================
module wb_pwm_buffered_channel
    import wb_pwm_pkg::*;
#(
    parameter int RESOLUTION = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  en,
    input  logic                  boundary,
    input  logic                  wr,
    input  logic [RESOLUTION-1:0] wdata,
    input  logic [RESOLUTION-1:0] cnt,
    input  logic                  invert,
    output logic [RESOLUTION-1:0] shadow,
    output logic                  pwm
);

    logic [RESOLUTION-1:0] r_shadow;
    logic [RESOLUTION-1:0] r_active;
    logic                  r_pwm;
    logic [RESOLUTION-1:0] w_load;
    logic                  w_raw;

    // A write landing on the reload cycle is forwarded so it is not lost
    // for a whole period behind the stale shadow value.
    assign w_load = wr ? wdata : r_shadow;

    // Disabled channels drive a raw low so the pin shows only the polarity.
    assign w_raw  = en & (cnt < r_active);

    // Shadow duty register, written from the bus
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_shadow <= '0;
        end else if (wr) begin
            r_shadow <= wdata;
        end
    end

    // Active duty: tracks shadow while disabled, otherwise reloads on boundary
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_active <= '0;
        end else if (!en || boundary) begin
            r_active <= w_load;
        end
    end

    // Registered, polarity-adjusted output
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= w_raw ^ invert;
        end
    end

    assign shadow = r_shadow;
    assign pwm    = r_pwm;

endmodule : wb_pwm_buffered_channel
`default_nettype wire

// File: rtl/wb_pwm_buffered.sv
`default_nettype none
// ============================================================================
//  Module  : wb_pwm_buffered
//  Purpose : Multi-channel double-buffered PWM on a Wishbone B4 pipelined
//            slave. Holds bus decode/readback, runtime prescaler and the
//            shared period counter; per-channel logic lives in
//            wb_pwm_buffered_channel.
//  Config  : define WB_PWM_CENTER_EN to enable center-aligned mode
//            (CTRL.CENTER writable, up/down counter). Without it CTRL.CENTER
//            reads 0 and only edge-aligned mode exists.
//  Rev     : 1.0  initial release
// ============================================================================
module wb_pwm_buffered
    import wb_pwm_pkg::*;
#(
    parameter int CHANNEL_NUM = 4,
    parameter int RESOLUTION  = 8,
    parameter int PRESCALE_W  = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [3:0]             wb_adr_i,
    input  logic [31:0]            wb_dat_i,
    output logic [31:0]            wb_dat_o,
    output logic                   wb_stall_o,
    output logic                   wb_ack_o,
    output logic [CHANNEL_NUM-1:0] pwm_channel
);

    // Last counter value before wrap / turnaround (MAX-1)
    localparam logic [RESOLUTION-1:0] c_CNT_TOP = {{(RESOLUTION-1){1'b1}}, 1'b0};

    logic                              w_req;
    logic                              w_wr;
    logic                              w_rd;
    logic                              w_restart;
    logic                              w_tick;
    logic                              w_boundary;
    logic                              w_center;
    logic [31:0]                       w_rdata;
    logic [RESOLUTION-1:0]             w_cnt_nxt;
    logic [CHANNEL_NUM*RESOLUTION-1:0] w_shadow;
    logic                              w_unused;

    logic [CHANNEL_NUM-1:0]            r_invert;
    logic [PRESCALE_W-1:0]             r_prescale;
    logic                              r_en;
    logic [PRESCALE_W-1:0]             r_pcnt;
    logic [RESOLUTION-1:0]             r_cnt;
    logic                              r_ack;
    logic [31:0]                       r_dat;

`ifdef WB_PWM_CENTER_EN
    logic                              r_center;
    pwm_dir_e                          r_dir;
    pwm_dir_e                          w_dir_nxt;
`endif

    assign w_req = wb_cyc_i & wb_stb_i;
    assign w_wr  = w_req & wb_we_i;
    assign w_rd  = w_req & ~wb_we_i;

    // Only the low data bits are meaningful; the rest are deliberately dropped.
    assign w_unused = ^wb_dat_i;

`ifdef WB_PWM_CENTER_EN
    assign w_center  = r_center;
    // Flipping the alignment mode mid-run would leave cnt mid-ramp in the
    // wrong shape, so the counter starts over from 0 counting up.
    assign w_restart = w_wr && (wb_adr_i == ADR_CTRL)
                       && (wb_dat_i[CTRL_CENTER] != r_center);
`else
    assign w_center  = 1'b0;
    assign w_restart = 1'b0;
`endif

    // Prescaler tick; >= lets a lowered PRESCALE take effect at once.
    assign w_tick = r_en & (r_pcnt >= r_prescale);

    // Configuration registers written from the bus; unmapped writes dropped
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_invert   <= '0;
            r_prescale <= '0;
            r_en       <= 1'b0;
`ifdef WB_PWM_CENTER_EN
            r_center   <= 1'b0;
`endif
        end else if (w_wr) begin
            case (wb_adr_i)
                ADR_INVERT:   r_invert   <= wb_dat_i[CHANNEL_NUM-1:0];
                ADR_PRESCALE: r_prescale <= wb_dat_i[PRESCALE_W-1:0];
                ADR_CTRL: begin
                    r_en     <= wb_dat_i[CTRL_EN];
`ifdef WB_PWM_CENTER_EN
                    r_center <= wb_dat_i[CTRL_CENTER];
`endif
                end
                default: ;
            endcase
        end
    end

    // Prescale counter: runs 0..PRESCALE while enabled, parked at 0 otherwise
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_pcnt <= '0;
        end else if (!r_en || w_restart || w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    // Shared counter next state and period-boundary detection
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_boundary = 1'b0;
`ifdef WB_PWM_CENTER_EN
        w_dir_nxt  = r_dir;
`endif
        if (!r_en || w_restart) begin
            w_cnt_nxt = '0;
`ifdef WB_PWM_CENTER_EN
            w_dir_nxt = DIR_UP;
`endif
        end else if (w_tick) begin
`ifdef WB_PWM_CENTER_EN
            if (r_center) begin
                // Each end value is held for two ticks, giving 2*MAX ticks
                if (r_dir == DIR_UP) begin
                    if (r_cnt == c_CNT_TOP) begin
                        w_dir_nxt = DIR_DOWN;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else begin
                    if (r_cnt == '0) begin
                        w_dir_nxt  = DIR_UP;
                        w_boundary = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end else
`endif
            begin
                if (r_cnt == c_CNT_TOP) begin
                    w_cnt_nxt  = '0;
                    w_boundary = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        end
    end

    // Shared counter state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_cnt <= '0;
`ifdef WB_PWM_CENTER_EN
            r_dir <= DIR_UP;
`endif
        end else begin
            r_cnt <= w_cnt_nxt;
`ifdef WB_PWM_CENTER_EN
            r_dir <= w_dir_nxt;
`endif
        end
    end

    // Readback multiplexer; unmapped addresses return 0
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (wb_adr_i == 4'(i)) begin
                w_rdata = 32'(w_shadow[i*RESOLUTION +: RESOLUTION]);
            end
        end
        case (wb_adr_i)
            ADR_INVERT:   w_rdata = 32'(r_invert);
            ADR_PRESCALE: w_rdata = 32'(r_prescale);
            ADR_CTRL:     w_rdata = 32'({w_center, r_en});
            default: ;
        endcase
    end

    // Bus response: single-cycle ack for every request, registered read data
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= w_rd ? w_rdata : 32'd0;
        end
    end

    assign wb_ack_o   = r_ack;
    assign wb_dat_o   = r_dat;
    assign wb_stall_o = 1'b0;

    for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_channel
        wb_pwm_buffered_channel #(
            .RESOLUTION (RESOLUTION)
        ) u_channel (
            .wb_clk_i  (wb_clk_i),
            .wb_rst_ni (wb_rst_ni),
            .en        (r_en),
            .boundary  (w_boundary),
            .wr        (w_wr && (wb_adr_i == 4'(g))),
            .wdata     (wb_dat_i[RESOLUTION-1:0]),
            .cnt       (r_cnt),
            .invert    (r_invert[g]),
            .shadow    (w_shadow[g*RESOLUTION +: RESOLUTION]),
            .pwm       (pwm_channel[g])
        );
    end

endmodule : wb_pwm_buffered
`default_nettype wire
